// File: rtl/color_sensor_seq.sv
// Colour-sensor front end: steps the photodiode filter through red, green and blue,
// averages the full sensor period on each channel and classifies the object.
module color_sensor_seq #(
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned SAMPLE_INTERVAL = 25000000,
  parameter int unsigned SETTLE_EDGES    = 2,
  parameter int unsigned AVG_SHIFT       = 2,
  parameter int unsigned TIMEOUT         = 200000,
  parameter int unsigned RED_LO          = 18000,
  parameter int unsigned RED_HI          = 23000,
  parameter int unsigned GREEN_LO        = 10400,
  parameter int unsigned GREEN_HI        = 17900
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             sensor_clk,
  output logic [1:0]       filtro_sel,
  output logic             es_rojo,
  output logic             es_verde,
  output logic             es_otro,
  output logic             result_valid,
  output logic [CNT_W-1:0] period_r,
  output logic [CNT_W-1:0] period_g,
  output logic [CNT_W-1:0] period_b,
  output logic             sensor_fault,
  output logic             busy
);

  localparam int unsigned AccW   = CNT_W + AVG_SHIFT;
  localparam int unsigned NumAvg = 1 << AVG_SHIFT;

  localparam logic [1:0] FilRed   = 2'b00;
  localparam logic [1:0] FilGreen = 2'b11;
  localparam logic [1:0] FilBlue  = 2'b01;

  typedef enum logic [2:0] {StIdle, StSettle, StMeasure, StNext, StClassify} state_e;
  typedef enum logic [1:0] {ChRed, ChGreen, ChBlue} chan_e;

  state_e state_q, state_d;
  chan_e  ch_q, ch_d;

  logic [2:0]       sync_q;
  logic [31:0]      tmr_q, tmr_d;
  logic [1:0]       filtro_q, filtro_d;
  logic             busy_q, busy_d;
  logic [15:0]      edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [AccW-1:0]  acc_q, acc_d, acc_sum;
  logic [31:0]      to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] res_q, res_d;
  logic [2:0]       fault_q, fault_d, ch_onehot;
  logic [CNT_W-1:0] sh_r_q, sh_r_d, sh_g_q, sh_g_d;
  logic [CNT_W-1:0] per_r_q, per_r_d, per_g_q, per_g_d, per_b_q, per_b_d;
  logic             rojo_q, rojo_d, verde_q, verde_d, otro_q, otro_d;
  logic             valid_q, valid_d, sfault_q, sfault_d;

  logic rise, tick, timeout, settle_done, meas_done;
  logic is_red, is_green, any_fault;

  // Two-stage synchronizer plus one delayed copy for rising-edge detection.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], sensor_clk};
  end

  assign rise = sync_q[1] & ~sync_q[2];

  // Free-running sweep interval timer; never gated by the FSM.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end

  assign tick  = (tmr_q == 32'(SAMPLE_INTERVAL - 1));
  assign tmr_d = tick ? '0 : tmr_q + 32'd1;

  // An edge in the same cycle as the timeout wins, so timeout requires no rise.
  assign timeout     = !rise && (to_cnt_q == 32'(TIMEOUT - 1));
  assign settle_done = rise && (edge_cnt_q == 16'(SETTLE_EDGES - 1));
  assign meas_done   = rise && (edge_cnt_q == 16'(NumAvg - 1));
  assign acc_sum     = acc_q + AccW'(per_cnt_q);
  assign ch_onehot   = 3'b001 << ch_q;

  assign any_fault = |fault_q;
  assign is_red    = (sh_r_q > CNT_W'(RED_LO)) && (sh_r_q < CNT_W'(RED_HI)) &&
                     (sh_r_q < sh_g_q);
  assign is_green  = (sh_g_q > CNT_W'(GREEN_LO)) && (sh_g_q < CNT_W'(GREEN_HI)) &&
                     (sh_g_q < sh_r_q);

  // State register.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (tick) state_d = StSettle;
      StSettle:   if (settle_done || timeout) state_d = settle_done ? StMeasure : StNext;
      StMeasure:  if (meas_done || timeout) state_d = StNext;
      StNext:     state_d = (ch_q == ChBlue) ? StClassify : StSettle;
      StClassify: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Datapath and output next-state values.
  always_comb begin
    ch_d       = ch_q;
    filtro_d   = filtro_q;
    busy_d     = busy_q;
    edge_cnt_d = edge_cnt_q;
    per_cnt_d  = per_cnt_q;
    acc_d      = acc_q;
    to_cnt_d   = to_cnt_q;
    res_d      = res_q;
    fault_d    = fault_q;
    sh_r_d     = sh_r_q;
    sh_g_d     = sh_g_q;
    per_r_d    = per_r_q;
    per_g_d    = per_g_q;
    per_b_d    = per_b_q;
    rojo_d     = rojo_q;
    verde_d    = verde_q;
    otro_d     = otro_q;
    sfault_d   = sfault_q;
    valid_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (tick) begin
          ch_d       = ChRed;
          filtro_d   = FilRed;
          busy_d     = 1'b1;
          edge_cnt_d = '0;
          per_cnt_d  = '0;
          acc_d      = '0;
          to_cnt_d   = '0;
          fault_d    = '0;
        end
      end
      StSettle: begin
        to_cnt_d = rise ? '0 : to_cnt_q + 32'd1;
        if (rise) begin
          edge_cnt_d = settle_done ? '0 : edge_cnt_q + 16'd1;
          // The edge that ends settling opens the first measured period.
          if (settle_done) per_cnt_d = CNT_W'(1);
        end else if (timeout) begin
          res_d   = '1;
          fault_d = fault_q | ch_onehot;
        end
      end
      StMeasure: begin
        to_cnt_d  = rise ? '0 : to_cnt_q + 32'd1;
        per_cnt_d = rise ? CNT_W'(1) : per_cnt_q + CNT_W'(1);
        if (rise) begin
          acc_d      = acc_sum;
          edge_cnt_d = edge_cnt_q + 16'd1;
          if (meas_done) res_d = CNT_W'(acc_sum >> AVG_SHIFT);
        end else if (timeout) begin
          res_d   = '1;
          fault_d = fault_q | ch_onehot;
        end
      end
      StNext: begin
        edge_cnt_d = '0;
        per_cnt_d  = '0;
        acc_d      = '0;
        to_cnt_d   = '0;
        case (ch_q)
          ChRed: begin
            sh_r_d   = res_q;
            ch_d     = ChGreen;
            filtro_d = FilGreen;
          end
          ChGreen: begin
            sh_g_d   = res_q;
            ch_d     = ChBlue;
            filtro_d = FilBlue;
          end
          default: begin
            // Blue done: publish everything so it is visible during the classify cycle.
            filtro_d = FilRed;
            busy_d   = 1'b0;
            valid_d  = 1'b1;
            per_r_d  = sh_r_q;
            per_g_d  = sh_g_q;
            per_b_d  = res_q;
            sfault_d = any_fault;
            rojo_d   = !any_fault && is_red;
            verde_d  = !any_fault && !is_red && is_green;
            otro_d   = any_fault || (!is_red && !is_green);
          end
        endcase
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q       <= ChRed;
      filtro_q   <= FilRed;
      busy_q     <= 1'b0;
      edge_cnt_q <= '0;
      per_cnt_q  <= '0;
      acc_q      <= '0;
      to_cnt_q   <= '0;
      res_q      <= '0;
      fault_q    <= '0;
      sh_r_q     <= '0;
      sh_g_q     <= '0;
      per_r_q    <= '0;
      per_g_q    <= '0;
      per_b_q    <= '0;
      rojo_q     <= 1'b0;
      verde_q    <= 1'b0;
      otro_q     <= 1'b1;
      valid_q    <= 1'b0;
      sfault_q   <= 1'b0;
    end else begin
      ch_q       <= ch_d;
      filtro_q   <= filtro_d;
      busy_q     <= busy_d;
      edge_cnt_q <= edge_cnt_d;
      per_cnt_q  <= per_cnt_d;
      acc_q      <= acc_d;
      to_cnt_q   <= to_cnt_d;
      res_q      <= res_d;
      fault_q    <= fault_d;
      sh_r_q     <= sh_r_d;
      sh_g_q     <= sh_g_d;
      per_r_q    <= per_r_d;
      per_g_q    <= per_g_d;
      per_b_q    <= per_b_d;
      rojo_q     <= rojo_d;
      verde_q    <= verde_d;
      otro_q     <= otro_d;
      valid_q    <= valid_d;
      sfault_q   <= sfault_d;
    end
  end

  assign filtro_sel   = filtro_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign period_r     = per_r_q;
  assign period_g     = per_g_q;
  assign period_b     = per_b_q;
  assign es_rojo      = rojo_q;
  assign es_verde     = verde_q;
  assign es_otro      = otro_q;
  assign sensor_fault = sfault_q;

endmodule
